sram_stage_sequencer: RTL and testbench

- Top-level SRAM ownership sequencer, generalised to NUM_STAGES processing stages.
- Arbitrates the single SRAM port between a loader (UART), an ordered chain of processing stages and the display reader (VGA).
- Owns the enable/done handshake with each stage, the loader timeout, a run mask, a skip-load start and a run-cycle counter.
- Sits between the SRAM controller and all SRAM clients.

---
 rtl/sram_stage_sequencer_pkg.sv | 27 ++
 rtl/sram_stage_sequencer_if.sv | 12 +
 rtl/sram_stage_sequencer_client_mux.sv | 47 ++++
 rtl/sram_stage_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_sram_stage_sequencer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_stage_sequencer_pkg.sv
// Shared types for the SRAM ownership sequencer: state encoding (also shown on LEDs)
// and the stage-count ceiling.
package sram_stage_sequencer_pkg;

   localparam int MAX_STAGES = 8;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD_EN   = 3'd1,
      S_LOAD_WAIT = 3'd2,
      S_STAGE_SEL = 3'd3,
      S_STAGE     = 3'd4,
      S_DONE      = 3'd5
   } seq_state_t;

   // Lowest set bit of mask at or above start_idx; returns {found, index}.
   function automatic logic [3:0] next_set_index(input logic [MAX_STAGES-1:0] mask,
                                                 input logic [3:0] start_idx);
      logic [3:0] r;
      r = '0;
      for (int i = MAX_STAGES - 1; i >= 0; i--) begin
         if (mask[i] && (4'(i) >= start_idx)) r = {1'b1, 3'(i)};
      end
      return r;
   endfunction

endpackage

// File: rtl/sram_stage_sequencer_if.sv
// Muxed SRAM request bus between the sequencer and the SRAM controller.
interface sram_stage_sequencer_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] SRAM_address;
   logic [DATA_W-1:0] SRAM_write_data;
   logic              SRAM_we_n;

   modport master (output SRAM_address, output SRAM_write_data, output SRAM_we_n);
   modport slave  (input  SRAM_address, input  SRAM_write_data, input  SRAM_we_n);
endinterface

// File: rtl/sram_stage_sequencer_client_mux.sv
// Combinational SRAM port selection: loader while loading, the active stage while
// running, otherwise the display reader with writes suppressed.
module sram_client_mux
   import sram_stage_sequencer_pkg::*;
#(
   parameter int NUM_STAGES = 2,
   parameter int ADDR_W     = 18,
   parameter int DATA_W     = 16
) (
   input  seq_state_t                     state,
   input  logic [2:0]                     cur_stage,
   input  logic [ADDR_W-1:0]              loader_addr,
   input  logic [DATA_W-1:0]              loader_wdata,
   input  logic                           loader_we_n,
   input  logic [NUM_STAGES*ADDR_W-1:0]   stage_addr,
   input  logic [NUM_STAGES*DATA_W-1:0]   stage_wdata,
   input  logic [NUM_STAGES-1:0]          stage_we_n,
   input  logic [ADDR_W-1:0]              disp_addr,
   output logic [ADDR_W-1:0]              sram_addr,
   output logic [DATA_W-1:0]              sram_wdata,
   output logic                           sram_we_n
);

   always_comb begin
      sram_addr  = disp_addr;
      sram_wdata = loader_wdata;
      sram_we_n  = 1'b1;
      case (state)
         S_LOAD_EN, S_LOAD_WAIT: begin
            sram_addr  = loader_addr;
            sram_wdata = loader_wdata;
            sram_we_n  = loader_we_n;
         end
         S_STAGE: begin
            for (int k = 0; k < NUM_STAGES; k++) begin
               if (3'(k) == cur_stage) begin
                  sram_addr  = stage_addr[k*ADDR_W +: ADDR_W];
                  sram_wdata = stage_wdata[k*DATA_W +: DATA_W];
                  sram_we_n  = stage_we_n[k];
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sram_stage_sequencer.sv
// SRAM ownership sequencer: loader, then an ordered chain of masked stages, then the
// display reader; owns all enable/done handshakes and the loader idle timeout.
module sram_stage_sequencer
   import sram_stage_sequencer_pkg::*;
#(
   parameter int NUM_STAGES     = 2,
   parameter int ADDR_W         = 18,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic                           Clock_50,
   input  logic                           Reset,
   input  logic                           Start,
   input  logic                           Start_skip_load,
   input  logic                           Abort,
   input  logic [NUM_STAGES-1:0]          Stage_mask,
   input  logic [ADDR_W-1:0]              Loader_addr,
   input  logic [DATA_W-1:0]              Loader_wdata,
   input  logic                           Loader_we_n,
   output logic                           Loader_init,
   output logic                           Loader_enable,
   input  logic [NUM_STAGES*ADDR_W-1:0]   Stage_addr,
   input  logic [NUM_STAGES*DATA_W-1:0]   Stage_wdata,
   input  logic [NUM_STAGES-1:0]          Stage_we_n,
   input  logic [NUM_STAGES-1:0]          Stage_done,
   output logic [NUM_STAGES-1:0]          Stage_enable,
   input  logic [ADDR_W-1:0]              Disp_addr,
   output logic                           Disp_enable,
   sram_stage_sequencer_if.master         sram,
   output logic                           Busy,
   output logic [2:0]                     Cur_stage,
   output logic [31:0]                    Run_cycles,
   output logic [2:0]                     Seq_state
);

   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   seq_state_t            state_q, state_d;
   logic [NUM_STAGES-1:0] run_mask_q, run_mask_d, stage_en_d;
   logic [31:0]           timer_q, timer_d, run_cycles_d;
   logic [2:0]            cur_d;
   logic                  disp_en_d, ld_init_d, ld_en_d;
   logic [MAX_STAGES-1:0] sel_ext, run_ext;
   logic [3:0]            pick;
   logic                  done_cur;
   logic [ADDR_W-1:0]     mux_addr;
   logic [DATA_W-1:0]     mux_wdata;
   logic                  mux_we_n;

   always_ff @(posedge Clock_50) begin
      if (Reset) begin
         state_q       <= S_IDLE;
         run_mask_q    <= '0;
         timer_q       <= '0;
         Stage_enable  <= '0;
         Disp_enable   <= 1'b0;
         Loader_init   <= 1'b0;
         Loader_enable <= 1'b0;
         Run_cycles    <= '0;
         Cur_stage     <= '0;
      end else begin
         state_q       <= state_d;
         run_mask_q    <= run_mask_d;
         timer_q       <= timer_d;
         Stage_enable  <= stage_en_d;
         Disp_enable   <= disp_en_d;
         Loader_init   <= ld_init_d;
         Loader_enable <= ld_en_d;
         Run_cycles    <= run_cycles_d;
         Cur_stage     <= cur_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      run_mask_d   = run_mask_q;
      stage_en_d   = Stage_enable;
      disp_en_d    = Disp_enable;
      ld_init_d    = 1'b0;
      ld_en_d      = 1'b0;
      run_cycles_d = Run_cycles;
      cur_d        = Cur_stage;
      pick         = '0;
      done_cur     = 1'b0;
      sel_ext      = '0;
      sel_ext[NUM_STAGES-1:0] = Stage_mask;
      run_ext      = '0;
      run_ext[NUM_STAGES-1:0] = run_mask_q;
      for (int k = 0; k < NUM_STAGES; k++) begin
         if (3'(k) == Cur_stage) done_cur = Stage_done[k];
      end

      // Any loader activity restarts the idle window; the count parks at the timeout value.
      if (Loader_init || !Loader_we_n) timer_d = '0;
      else if (state_q == S_LOAD_WAIT && timer_q != TIMEOUT_LAST) timer_d = timer_q + 32'd1;
      else timer_d = timer_q;

      case (state_q)
         S_IDLE: begin
            disp_en_d = 1'b1;
            if (Start) begin
               ld_init_d = 1'b1;
               disp_en_d = 1'b0;
               state_d   = S_LOAD_EN;
            end else if (Start_skip_load) begin
               state_d = S_STAGE_SEL;
            end
         end
         S_LOAD_EN: begin
            ld_en_d = 1'b1;
            state_d = S_LOAD_WAIT;
         end
         S_LOAD_WAIT: begin
            // A zero address means nothing was ever received, so keep waiting.
            if (Loader_we_n && timer_q == TIMEOUT_LAST && Loader_addr != '0) begin
               ld_init_d = 1'b1;
               state_d   = S_STAGE_SEL;
            end
         end
         S_STAGE_SEL: begin
            run_mask_d   = Stage_mask;
            run_cycles_d = '0;
            pick         = next_set_index(sel_ext, 4'd0);
            if (pick[3]) begin
               for (int k = 0; k < NUM_STAGES; k++) stage_en_d[k] = (3'(k) == pick[2:0]);
               cur_d   = pick[2:0];
               state_d = S_STAGE;
            end else begin
               state_d = S_DONE;
            end
         end
         S_STAGE: begin
            run_cycles_d = (Run_cycles == '1) ? Run_cycles : Run_cycles + 32'd1;
            if (done_cur) begin
               for (int k = 0; k < NUM_STAGES; k++) begin
                  if (3'(k) == Cur_stage) run_mask_d[k] = 1'b0;
               end
               // Hand over on the same edge so the next stage sees no gap cycle.
               pick = next_set_index(run_ext, {1'b0, Cur_stage} + 4'd1);
               if (pick[3]) begin
                  for (int k = 0; k < NUM_STAGES; k++) stage_en_d[k] = (3'(k) == pick[2:0]);
                  cur_d = pick[2:0];
               end else begin
                  stage_en_d = '0;
                  state_d    = S_DONE;
               end
            end
         end
         S_DONE: begin
            disp_en_d = 1'b1;
            cur_d     = '0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (Abort && state_q != S_IDLE) begin
         stage_en_d   = '0;
         disp_en_d    = 1'b1;
         ld_init_d    = 1'b0;
         ld_en_d      = 1'b0;
         cur_d        = '0;
         run_cycles_d = Run_cycles;
         state_d      = S_IDLE;
      end
   end

   sram_client_mux #(
      .NUM_STAGES (NUM_STAGES),
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W)
   ) u_client_mux (
      .state        (state_q),
      .cur_stage    (Cur_stage),
      .loader_addr  (Loader_addr),
      .loader_wdata (Loader_wdata),
      .loader_we_n  (Loader_we_n),
      .stage_addr   (Stage_addr),
      .stage_wdata  (Stage_wdata),
      .stage_we_n   (Stage_we_n),
      .disp_addr    (Disp_addr),
      .sram_addr    (mux_addr),
      .sram_wdata   (mux_wdata),
      .sram_we_n    (mux_we_n)
   );

   assign sram.SRAM_address    = mux_addr;
   assign sram.SRAM_write_data = mux_wdata;
   assign sram.SRAM_we_n       = mux_we_n;
   assign Busy                 = (state_q != S_IDLE);
   assign Seq_state            = state_q;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Directed plus randomized bench for sram_stage_sequencer with a stage-list reference model.
module tb_sram_stage_sequencer;
   import sram_stage_sequencer_pkg::*;

   localparam int NS = 3;
   localparam int AW = 18;
   localparam int DW = 16;
   localparam int TO = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, start, skip, abort;
   logic [NS-1:0]     mask;
   logic [AW-1:0]     ld_addr;
   logic [DW-1:0]     ld_wdata;
   logic              ld_we_n, ld_init, ld_en;
   logic [NS*AW-1:0]  st_addr;
   logic [NS*DW-1:0]  st_wdata;
   logic [NS-1:0]     st_we_n, st_done, st_en;
   logic [AW-1:0]     disp_addr;
   logic              disp_en, busy;
   logic [2:0]        cur, seq;
   logic [31:0]       run_cycles;

   sram_stage_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) sram ();

   sram_stage_sequencer #(
      .NUM_STAGES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .Clock_50(clk), .Reset(rst), .Start(start), .Start_skip_load(skip), .Abort(abort),
      .Stage_mask(mask), .Loader_addr(ld_addr), .Loader_wdata(ld_wdata), .Loader_we_n(ld_we_n),
      .Loader_init(ld_init), .Loader_enable(ld_en), .Stage_addr(st_addr), .Stage_wdata(st_wdata),
      .Stage_we_n(st_we_n), .Stage_done(st_done), .Stage_enable(st_en), .Disp_addr(disp_addr),
      .Disp_enable(disp_en), .sram(sram.master), .Busy(busy), .Cur_stage(cur),
      .Run_cycles(run_cycles), .Seq_state(seq)
   );

   int tests = 0;
   int fails = 0;
   int n, bad, total;
   int order[$];
   int dur[NS];
   logic [NS-1:0] m;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NS-1:0] onehot(input int k);
      logic [NS-1:0] r;
      r = '0;
      r[k] = 1'b1;
      return r;
   endfunction

   task automatic randomize_stage_bus();
      for (int k = 0; k < NS; k++) begin
         st_addr[k*AW +: AW]  = AW'($urandom);
         st_wdata[k*DW +: DW] = DW'($urandom);
      end
      st_we_n = NS'($urandom);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; skip = 1'b0; abort = 1'b0; mask = '0;
      ld_addr = '0; ld_wdata = '0; ld_we_n = 1'b1;
      st_addr = '0; st_wdata = '0; st_we_n = '1; st_done = '0;
      disp_addr = AW'($urandom);
      tick(); tick();

      check("rst_busy", busy, 0);
      check("rst_state", seq, 3'(S_IDLE));
      check("rst_stage_en", st_en, 0);
      check("rst_disp_en", disp_en, 0);
      check("rst_ld_pulses", {ld_init, ld_en}, 0);
      check("rst_cur_run", {cur, run_cycles}, 0);
      check("rst_sram_addr", sram.SRAM_address, disp_addr);
      check("rst_sram_we", sram.SRAM_we_n, 1);
      rst = 1'b0;
      tick();
      check("idle_disp_en", disp_en, 1);

      // Load of ten words followed by idle timeout, then a two-stage run.
      mask = 3'b011;
      start = 1'b1; tick(); start = 1'b0;
      check("load_en_state", seq, 3'(S_LOAD_EN));
      check("load_init_pulse", {ld_init, ld_en, disp_en}, 3'b100);
      tick();
      check("load_enable_pulse", {seq, ld_init, ld_en}, {3'(S_LOAD_WAIT), 2'b01});
      for (int i = 0; i < 10; i++) begin
         ld_addr = AW'(i); ld_wdata = DW'($urandom); ld_we_n = 1'b0;
         #1;
         if (i == 5) check("load_mux", {sram.SRAM_address, sram.SRAM_write_data, sram.SRAM_we_n},
                           {ld_addr, ld_wdata, 1'b0});
         tick();
      end
      ld_we_n = 1'b1;
      n = 0;
      while (seq != 3'(S_STAGE_SEL) && n < 3*TO) begin tick(); n++; end
      check("timeout_cycles", n, TO);
      check("timeout_init_pulse", ld_init, 1);
      tick();
      mask = 3'b100;
      randomize_stage_bus();
      #1;
      check("stage0_enable", {seq, st_en, cur}, {3'(S_STAGE), 3'b001, 3'd0});
      check("stage0_mux", {sram.SRAM_address, sram.SRAM_write_data, sram.SRAM_we_n},
            {st_addr[0 +: AW], st_wdata[0 +: DW], st_we_n[0]});
      repeat (20) tick();
      st_done = 3'b001; tick(); st_done = '0;
      check("handover_no_gap", {st_en, cur}, {3'b010, 3'd1});
      repeat (29) tick();
      st_done = 3'b010; tick(); st_done = '0;
      check("run_done_state", {seq, st_en, disp_en}, {3'(S_DONE), 3'b000, 1'b0});
      check("run_cycles", run_cycles, (20 + 1) + (29 + 1));
      tick();
      check("disp_back", {seq, disp_en, cur}, {3'(S_IDLE), 1'b1, 3'd0});
      repeat (3) tick();
      check("run_cycles_hold", run_cycles, 51);

      // Skip-load with an empty mask passes straight through.
      mask = '0; st_we_n = '0;
      skip = 1'b1; tick(); skip = 1'b0;
      check("skip_sel", {seq, sram.SRAM_we_n}, {3'(S_STAGE_SEL), 1'b1});
      tick();
      check("skip_done", {seq, st_en, sram.SRAM_we_n}, {3'(S_DONE), 3'b000, 1'b1});
      check("skip_run_cycles", run_cycles, 0);
      tick();
      check("skip_idle", seq, 3'(S_IDLE));
      st_we_n = '1;

      // Abort coinciding with the first done.
      mask = 3'b011;
      skip = 1'b1; tick(); skip = 1'b0; tick();
      repeat (3) tick();
      abort = 1'b1; st_done = 3'b001; tick(); abort = 1'b0; st_done = '0;
      check("abort_state", {seq, st_en, disp_en}, {3'(S_IDLE), 3'b000, 1'b1});
      bad = 0;
      repeat (5) begin tick(); if (st_en != '0) bad++; end
      check("abort_no_stage1", bad, 0);

      // Loader never receives data: no timeout.
      ld_addr = '0; ld_we_n = 1'b1;
      start = 1'b1; tick(); start = 1'b0; tick();
      bad = 0;
      repeat (3*TO) begin tick(); if (seq != 3'(S_LOAD_WAIT)) bad++; end
      check("no_data_wait", bad, 0);
      abort = 1'b1; tick(); abort = 1'b0;
      check("abort_load", seq, 3'(S_IDLE));

      // Done from an inactive stage is ignored, then reset lands mid-stage.
      mask = 3'b011;
      skip = 1'b1; tick(); skip = 1'b0; tick();
      st_done = 3'b010; tick(); st_done = '0;
      check("inactive_done", {seq, st_en, cur}, {3'(S_STAGE), 3'b001, 3'd0});
      st_done = 3'b001; tick(); st_done = '0;
      check("inactive_then_handover", st_en, 3'b010);
      repeat (4) tick();
      rst = 1'b1; tick();
      check("midrun_reset", {busy, st_en, disp_en, ld_init, ld_en, cur}, 0);
      check("midrun_reset_cnt", {seq, run_cycles}, {3'(S_IDLE), 32'd0});
      check("midrun_reset_addr", {sram.SRAM_address, sram.SRAM_we_n}, {disp_addr, 1'b1});
      rst = 1'b0; tick();

      // Randomized runs checked against an ordered list of selected stages.
      for (int it = 0; it < 12; it++) begin
         m = NS'($urandom);
         order.delete();
         total = 0;
         for (int k = 0; k < NS; k++) begin
            dur[k] = $urandom_range(0, 6);
            if (m[k]) begin order.push_back(k); total += dur[k] + 1; end
         end
         mask = m;
         skip = 1'b1; tick(); skip = 1'b0;
         tick();
         mask = NS'($urandom);
         foreach (order[j]) begin
            randomize_stage_bus();
            #1;
            check("rand_enable", {seq, st_en, cur}, {3'(S_STAGE), onehot(order[j]), 3'(order[j])});
            check("rand_mux_addr", sram.SRAM_address, st_addr[order[j]*AW +: AW]);
            repeat (dur[order[j]]) begin
               st_done = NS'($urandom) & ~onehot(order[j]);
               tick();
            end
            st_done = onehot(order[j]); tick(); st_done = '0;
         end
         check("rand_done", {seq, st_en}, {3'(S_DONE), 3'b000});
         check("rand_run_cycles", run_cycles, total);
         tick();
         check("rand_idle", seq, 3'(S_IDLE));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
